// File: rtl/smvm_pkg.sv
// rtl/smvm_pkg.sv - shared types, entry layout and sentinel helper for the SpMV scheduler
package smvm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FINISHED
  } sched_state_t;

  localparam int ENTRY_W   = 96;
  localparam int FIELD_W   = 32;
  localparam int VALUE_LSB = 64;
  localparam int COL_LSB   = 32;
  localparam int ROW_LSB   = 0;

  // Entry that tells the multiplier a lane has no more work: row = num_rows, value/col = 0
  function automatic logic [ENTRY_W-1:0] sentinel_entry(input int unsigned num_rows);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[ROW_LSB +: FIELD_W] = num_rows[FIELD_W-1:0];
    return e;
  endfunction

endpackage

// File: rtl/coo_lane_unpack.sv
// rtl/coo_lane_unpack.sv - per-lane COO field split with past-the-end masking
module coo_lane_unpack
  import smvm_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_ROWS     = 128,
  parameter int ADDR_W       = 10
) (
  input  logic [NUM_CHANNELS*ENTRY_W-1:0] entry_word,
  input  logic [ADDR_W-1:0]               word_idx,
  input  logic [31:0]                     nnz,
  output logic [NUM_CHANNELS*32-1:0]      values,
  output logic [NUM_CHANNELS*32-1:0]      col_id,
  output logic [NUM_CHANNELS*32-1:0]      row_id
);

  logic [ENTRY_W-1:0] entry;
  logic [31:0]        idx;

  // Split each lane and replace entries beyond the last nonzero with the sentinel
  always_comb begin
    values = '0;
    col_id = '0;
    row_id = '0;
    entry  = '0;
    idx    = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx   = 32'(word_idx) * 32'(NUM_CHANNELS) + 32'(k);
      entry = entry_word[k*ENTRY_W +: ENTRY_W];
      if (idx >= nnz) begin
        entry = sentinel_entry(NUM_ROWS);
      end
      values[k*32 +: 32] = entry[VALUE_LSB +: FIELD_W];
      col_id[k*32 +: 32] = entry[COL_LSB +: FIELD_W];
      row_id[k*32 +: 32] = entry[ROW_LSB +: FIELD_W];
    end
  end

endmodule

// File: rtl/smvm_stream_scheduler.sv
// rtl/smvm_stream_scheduler.sv - one-shot COO entry fetch and lane issue controller
module smvm_stream_scheduler
  import smvm_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_ROWS     = 128,
  parameter int NNZ_MAX      = 4096,
  parameter int ADDR_W       = 10
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            start,
  input  logic [31:0]                     nnz,
  output logic                            mem_rd_en,
  output logic [ADDR_W-1:0]               mem_addr,
  input  logic [NUM_CHANNELS*ENTRY_W-1:0] mem_rdata,
  output logic [NUM_CHANNELS*32-1:0]      values,
  output logic [NUM_CHANNELS*32-1:0]      col_id,
  output logic [NUM_CHANNELS*32-1:0]      row_id,
  output logic                            rdy,
  input  logic                            accum_done,
  output logic                            busy,
  output logic                            finished,
  output logic                            error,
  output logic [31:0]                     cycle_count
);

  sched_state_t state, state_n;
  logic [ADDR_W-1:0] w, last_w, idx_d;
  logic [31:0]       nnz_q;
  logic              rd_d;
  logic              accept, too_big;
  logic [NUM_CHANNELS*32-1:0] un_values, un_col_id, un_row_id;

  assign accept    = (state == ST_IDLE) && start;
  assign too_big   = nnz > 32'(NNZ_MAX);
  assign mem_rd_en = (state == ST_FETCH);
  assign mem_addr  = mem_rd_en ? w : '0;
  assign busy      = (state == ST_FETCH) || (state == ST_DRAIN);
  assign finished  = (state == ST_FINISHED);

  // Next-state selection for the job sequence
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (too_big)           state_n = ST_FINISHED;
          else if (nnz == 32'd0) state_n = ST_DRAIN;
          else                   state_n = ST_FETCH;
        end
      end
      ST_FETCH:    if (w == last_w) state_n = ST_DRAIN;
      ST_DRAIN:    if (accum_done)  state_n = ST_FINISHED;
      ST_FINISHED: state_n = ST_FINISHED;
      default:     state_n = ST_IDLE;
    endcase
  end

  // State, word counter, job latches and the cycle counter
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= ST_IDLE;
      w           <= '0;
      last_w      <= '0;
      nnz_q       <= '0;
      error       <= 1'b0;
      cycle_count <= '0;
      rd_d        <= 1'b0;
      idx_d       <= '0;
    end else begin
      state <= state_n;
      rd_d  <= mem_rd_en;
      idx_d <= w;
      if (accept) begin
        nnz_q       <= nnz;
        last_w      <= ADDR_W'((nnz - 32'd1) / 32'(NUM_CHANNELS));
        w           <= '0;
        error       <= too_big;
        cycle_count <= '0;
      end else begin
        if (state == ST_FETCH) w <= w + 1'b1;
        if (busy && (cycle_count != '1)) cycle_count <= cycle_count + 32'd1;
      end
    end
  end

  coo_lane_unpack #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .NUM_ROWS     (NUM_ROWS),
    .ADDR_W       (ADDR_W)
  ) u_unpack (
    .entry_word (mem_rdata),
    .word_idx   (idx_d),
    .nnz        (nnz_q),
    .values     (un_values),
    .col_id     (un_col_id),
    .row_id     (un_row_id)
  );

  // Output stage: load returned words, otherwise show the all-finished sentinel after issue
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rdy    <= 1'b0;
      values <= '0;
      col_id <= '0;
      row_id <= '0;
    end else begin
      rdy <= rd_d;
      if (rd_d) begin
        values <= un_values;
        col_id <= un_col_id;
        row_id <= un_row_id;
      end else if ((state == ST_DRAIN) || (state == ST_FINISHED)) begin
        values <= '0;
        col_id <= '0;
        row_id <= {NUM_CHANNELS{32'(NUM_ROWS)}};
      end
    end
  end

endmodule

// File: tb/tb_smvm_stream_scheduler.sv
// tb/tb_smvm_stream_scheduler.sv - self-checking bench for smvm_stream_scheduler
module tb_smvm_stream_scheduler;

  localparam int NC   = 4;
  localparam int NR   = 128;
  localparam int NMAX = 4096;
  localparam int AW   = 10;
  localparam int LW   = NC * 32;

  logic            clk = 1'b0;
  logic            rst_l = 1'b0;
  logic            start = 1'b0;
  logic            accum_done = 1'b0;
  logic [31:0]     nnz_in = '0;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [NC*96-1:0] mem_rdata = '0;
  logic [LW-1:0]   values, col_id, row_id;
  logic            rdy, busy, finished, error;
  logic [31:0]     cycle_count;

  logic [NC*96-1:0] ram [0:1023];
  logic [31:0] nz_val [0:NMAX-1];
  logic [31:0] nz_col [0:NMAX-1];
  logic [31:0] nz_row [0:NMAX-1];

  int n_cmp = 0;
  int n_bad = 0;

  smvm_stream_scheduler #(
    .NUM_CHANNELS (NC),
    .NUM_ROWS     (NR),
    .NNZ_MAX      (NMAX),
    .ADDR_W       (AW)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .start       (start),
    .nnz         (nnz_in),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .values      (values),
    .col_id      (col_id),
    .row_id      (row_id),
    .rdy         (rdy),
    .accum_done  (accum_done),
    .busy        (busy),
    .finished    (finished),
    .error       (error),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".rd_en"}, 128'(mem_rd_en), 128'(0));
    chk({tag, ".addr"},  128'(mem_addr), 128'(0));
    chk({tag, ".val"},   128'(values), 128'(0));
    chk({tag, ".col"},   128'(col_id), 128'(0));
    chk({tag, ".row"},   128'(row_id), 128'(0));
    chk({tag, ".rdy"},   128'(rdy), 128'(0));
    chk({tag, ".busy"},  128'(busy), 128'(0));
    chk({tag, ".fin"},   128'(finished), 128'(0));
    chk({tag, ".err"},   128'(error), 128'(0));
    chk({tag, ".cnt"},   128'(cycle_count), 128'(0));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_l = 1'b0;
    start = 1'b0;
    accum_done = 1'b0;
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  // Build the nonzero list, then lay it out into RAM words; padding lanes get random junk
  task automatic load_job(input int unsigned nnz);
    int unsigned nw;
    logic [31:0] v, c, r;
    if (nnz > NMAX) return;
    nw = (nnz + NC - 1) / NC;
    for (int e = 0; e < int'(nw) * NC; e++) begin
      v = $urandom;
      c = $urandom;
      r = ($urandom_range(0, 7) == 0) ? 32'(NR + $urandom_range(0, 1000)) : 32'($urandom_range(0, NR - 1));
      if (e < int'(nnz)) begin
        nz_val[e] = v;
        nz_col[e] = c;
        nz_row[e] = r;
      end
      ram[e / NC][(e % NC) * 96 +: 96] = {v, c, r};
    end
  endtask

  // Expected lane field (0 value, 1 col, 2 row) for word w of a job with nnz entries
  function automatic logic [LW-1:0] exp_lanes(input int w, input int fld, input int unsigned nnz);
    logic [LW-1:0] o;
    int e;
    o = '0;
    for (int k = 0; k < NC; k++) begin
      e = w * NC + k;
      if (e < int'(nnz)) o[k*32 +: 32] = (fld == 0) ? nz_val[e] : (fld == 1) ? nz_col[e] : nz_row[e];
      else               o[k*32 +: 32] = (fld == 2) ? 32'(NR) : 32'd0;
    end
    return o;
  endfunction

  task automatic run_job(input int unsigned nnz);
    bit err;
    int nw, s, f, last;
    logic [LW-1:0] ev, ec, er;
    bit exp_rdy;
    apply_reset();
    load_job(nnz);
    err  = nnz > NMAX;
    nw   = err ? 0 : int'((nnz + NC - 1) / NC);
    s    = (nw == 0) ? 1 : nw + 2;
    f    = err ? 0 : s + 4;
    last = err ? 4 : f + 3;
    start  = 1'b1;
    nnz_in = nnz;
    for (int t = 0; t <= last; t++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (!err && t == 0 && nw >= 1) begin start = 1'b1; nnz_in = 32'd1; end
      if (t == f + 1) begin start = 1'b1; nnz_in = 32'd3; end
      accum_done = !err && (t == s + 3);

      chk($sformatf("n%0d.t%0d.rd_en", nnz, t), 128'(mem_rd_en), 128'(t < nw));
      if (t < nw) chk($sformatf("n%0d.t%0d.addr", nnz, t), 128'(mem_addr), 128'(t));
      exp_rdy = (t >= 2) && (t < nw + 2);
      chk($sformatf("n%0d.t%0d.rdy", nnz, t), 128'(rdy), 128'(exp_rdy));
      if (exp_rdy) begin
        ev = exp_lanes(t - 2, 0, nnz);
        ec = exp_lanes(t - 2, 1, nnz);
        er = exp_lanes(t - 2, 2, nnz);
      end else if (err ? (t >= 1) : (t >= s)) begin
        ev = '0;
        ec = '0;
        er = {NC{32'(NR)}};
      end else begin
        ev = '0;
        ec = '0;
        er = '0;
      end
      chk($sformatf("n%0d.t%0d.val", nnz, t), 128'(values), 128'(ev));
      chk($sformatf("n%0d.t%0d.col", nnz, t), 128'(col_id), 128'(ec));
      chk($sformatf("n%0d.t%0d.row", nnz, t), 128'(row_id), 128'(er));
      chk($sformatf("n%0d.t%0d.busy", nnz, t), 128'(busy), 128'(!err && t < f));
      chk($sformatf("n%0d.t%0d.fin", nnz, t), 128'(finished), 128'(err || t >= f));
      chk($sformatf("n%0d.t%0d.err", nnz, t), 128'(error), 128'(err));
      chk($sformatf("n%0d.t%0d.cnt", nnz, t), 128'(cycle_count), 128'(err ? 0 : (t < f ? t : f)));
    end
    start = 1'b0;
    accum_done = 1'b0;
  endtask

  task automatic mid_job_reset();
    apply_reset();
    load_job(20);
    start  = 1'b1;
    nnz_in = 32'd20;
    for (int t = 0; t <= 3; t++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("mid.t%0d.addr", t), 128'(mem_addr), 128'(t));
    end
    #2;
    rst_l = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk);
    rst_l  = 1'b1;
    start  = 1'b1;
    nnz_in = 32'd20;
    for (int t = 0; t <= 1; t++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("restart.t%0d.rd_en", t), 128'(mem_rd_en), 128'(1));
      chk($sformatf("restart.t%0d.addr", t), 128'(mem_addr), 128'(t));
    end
  endtask

  initial begin
    #1;
    check_reset_values("power_on");
    run_job(8);
    run_job(5);
    run_job(0);
    run_job(NMAX + 1);
    run_job(32'hFFFF_FFFF);
    mid_job_reset();
    run_job(1);
    run_job(NMAX);
    for (int i = 0; i < 6; i++) run_job($urandom_range(1, 64));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
